// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: register write (dev, reg, data) or current-address read.
// Bus timing is built from quarter-period ticks; SCL stretching freezes the tick counter.
module i2c_master_ctrl #(
  parameter int QTR_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic       cmdRw,
  input  logic [6:0] cmdDevAddr,
  input  logic [7:0] cmdRegAddr,
  input  logic [7:0] cmdWrData,
  output logic [7:0] rdData,
  output logic       done,
  output logic       ackErr,
  output logic       sclOut,
  output logic       sdaOut,
  input  logic       sclIn,
  input  logic       sdaIn
);

  // state   | meaning
  // IDLE    | bus released, waiting for a command
  // START_A | SDA and SCL high, bus-free setup
  // START_B | q0: SDA low (START), q1: SCL low
  // BIT     | one data bit, four quarters
  // ACK     | ninth bit: slave ACK or master NAK
  // STOP_A  | SCL low, SDA low
  // STOP_B  | SCL high, SDA low
  // STOP_C  | SDA high (STOP)
  // DONE    | one-cycle done pulse
  typedef enum logic [3:0] {
    IDLE, START_A, START_B, BIT, ACK, STOP_A, STOP_B, STOP_C, DONE
  } state_t;

  localparam logic [7:0] QTR_MAX = 8'(QTR_DIV - 1);

  state_t     r_state;
  logic [7:0] r_qcnt;
  logic [1:0] r_q;
  logic [2:0] r_bit;
  logic [1:0] r_byte;
  logic       r_rw;
  logic [6:0] r_dev;
  logic [7:0] r_reg;
  logic [7:0] r_wdata;
  logic [7:0] r_shift;
  logic [7:0] r_rd;
  logic       r_samp;
  logic       r_done;
  logic       r_ackerr;
  logic       r_scl;
  logic       r_sda;
  logic       r_ready;

  logic       w_stall;
  logic       w_tick;
  logic [7:0] w_cur_byte;
  logic       w_is_rx;
  logic       w_nxt_bit;
  logic       w_nxt_msb;
  logic       w_last_ack;

  assign w_stall = r_scl & ~sclIn;
  assign w_tick  = (r_qcnt == 8'd0) & ~w_stall;

  always_comb begin
    w_cur_byte = r_wdata;
    case (r_byte)
      2'd0:    w_cur_byte = {r_dev, r_rw};
      2'd1:    w_cur_byte = r_reg;
      default: w_cur_byte = r_wdata;
    endcase
  end

  // During the read data byte the master keeps SDA released
  assign w_is_rx    = r_rw & (r_byte == 2'd1);
  assign w_nxt_bit  = w_is_rx | w_cur_byte[3'd6 - r_bit];
  assign w_nxt_msb  = r_rw | ((r_byte == 2'd0) ? r_reg[7] : r_wdata[7]);
  assign w_last_ack = r_rw ? (r_byte == 2'd1) : (r_byte == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_qcnt   <= QTR_MAX;
      r_q      <= 2'd0;
      r_bit    <= 3'd0;
      r_byte   <= 2'd0;
      r_rw     <= 1'b0;
      r_dev    <= 7'd0;
      r_reg    <= 8'd0;
      r_wdata  <= 8'd0;
      r_shift  <= 8'd0;
      r_rd     <= 8'd0;
      r_samp   <= 1'b0;
      r_done   <= 1'b0;
      r_ackerr <= 1'b0;
      r_scl    <= 1'b1;
      r_sda    <= 1'b1;
      r_ready  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE || r_state == DONE || w_tick)
        r_qcnt <= QTR_MAX;
      else if (!w_stall)
        r_qcnt <= r_qcnt - 8'd1;

      case (r_state)
        IDLE: begin
          r_scl <= 1'b1;
          r_sda <= 1'b1;
          if (cmdValid && r_ready) begin
            r_rw     <= cmdRw;
            r_dev    <= cmdDevAddr;
            r_reg    <= cmdRegAddr;
            r_wdata  <= cmdWrData;
            r_ready  <= 1'b0;
            r_ackerr <= 1'b0;
            r_q      <= 2'd0;
            r_bit    <= 3'd0;
            r_byte   <= 2'd0;
            r_state  <= START_A;
          end
        end
        START_A: if (w_tick) begin
          r_sda   <= 1'b0;
          r_state <= START_B;
        end
        START_B: if (w_tick) begin
          if (r_q == 2'd0) begin
            r_q   <= 2'd1;
            r_scl <= 1'b0;
          end else begin
            r_q     <= 2'd0;
            r_sda   <= r_dev[6];
            r_state <= BIT;
          end
        end
        BIT: if (w_tick) begin
          r_q <= r_q + 2'd1;
          case (r_q)
            2'd1: r_scl <= 1'b1;
            2'd2: if (w_is_rx) r_shift <= {r_shift[6:0], sdaIn};
            2'd3: begin
              r_scl <= 1'b0;
              if (r_bit == 3'd7) begin
                r_bit   <= 3'd0;
                r_sda   <= 1'b1;
                r_state <= ACK;
                if (w_is_rx) r_rd <= r_shift;
              end else begin
                r_bit <= r_bit + 3'd1;
                r_sda <= w_nxt_bit;
              end
            end
            default: ;
          endcase
        end
        ACK: if (w_tick) begin
          r_q <= r_q + 2'd1;
          case (r_q)
            2'd1: r_scl <= 1'b1;
            2'd2: r_samp <= sdaIn;
            2'd3: begin
              r_scl <= 1'b0;
              if (!w_is_rx && r_samp) begin
                r_ackerr <= 1'b1;
                r_sda    <= 1'b0;
                r_state  <= STOP_A;
              end else if (w_last_ack) begin
                r_sda   <= 1'b0;
                r_state <= STOP_A;
              end else begin
                r_byte  <= r_byte + 2'd1;
                r_sda   <= w_nxt_msb;
                r_state <= BIT;
              end
            end
            default: ;
          endcase
        end
        STOP_A: if (w_tick) begin
          r_scl   <= 1'b1;
          r_state <= STOP_B;
        end
        STOP_B: if (w_tick) begin
          r_sda   <= 1'b1;
          r_state <= STOP_C;
        end
        STOP_C: if (w_tick) begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmdReady = r_ready;
  assign rdData   = r_rd;
  assign done     = r_done;
  assign ackErr   = r_ackerr;
  assign sclOut   = r_scl;
  assign sdaOut   = r_sda;

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter QTR_DIV, default 4: number of clk cycles per quarter SCL period, legal values 2..255.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port cmdValid, input, 1 bit: command request.
REQ-005 SHALL have port cmdReady, output, 1 bit: block idle and able to accept a command.
REQ-006 SHALL have port cmdRw, input, 1 bit: transfer direction; 0 = write, 1 = read.
REQ-007 SHALL have port cmdDevAddr, input, 7 bits: target device address.
REQ-008 SHALL have port cmdRegAddr, input, 8 bits: register address, used by writes only.
REQ-009 SHALL have port cmdWrData, input, 8 bits: write data byte.
REQ-010 SHALL have port rdData, output, 8 bits: byte received by the last read.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking transaction completion.
REQ-012 SHALL have port ackErr, output, 1 bit: slave NAK seen in the last transaction; valid from done until the next accept.
REQ-013 SHALL have port sclOut, output, 1 bit: SCL drive; 0 = pull low, 1 = release.
REQ-014 SHALL have port sdaOut, output, 1 bit: SDA drive; 0 = pull low, 1 = release.
REQ-015 SHALL have port sclIn, input, 1 bit: sampled SCL bus level.
REQ-016 SHALL have port sdaIn, input, 1 bit: sampled SDA bus level.

Function
REQ-017 SHALL accept a command when cmdValid and cmdReady are both 1 on a clk edge; all cmd* inputs are registered at that edge and cmdReady drops to 0 in the next cycle.
REQ-018 SHALL sequence a write as: START, byte {cmdDevAddr,0}, slave ACK, cmdRegAddr, slave ACK, cmdWrData, slave ACK, STOP.
REQ-019 SHALL sequence a read as: START, byte {cmdDevAddr,1}, slave ACK, 8 bits shifted into rdData MSB first, master NAK (sdaOut=1), STOP.
REQ-020 SHALL implement states IDLE, START_A, START_B, BIT, ACK, STOP_A, STOP_B, STOP_C, DONE.
REQ-021 SHALL time each state in quarter ticks: a counter counts QTR_DIV-1 down to 0, and each zero is one tick.
REQ-022 START_A SHALL hold sdaOut=1 and sclOut=1 for 1 tick; START_B SHALL drive sdaOut=0 for 1 tick, then sclOut=0 for 1 tick.
REQ-023 Each data and ACK bit SHALL take 4 ticks:
- q0: sclOut=0; sdaOut updated to the new bit, MSB first; released (1) during slave ACK and master read bits.
- q1: sclOut=0.
- q2, q3: sclOut=1; sdaIn sampled on the last clk of q2.
REQ-024 A bit counter (3 bits) and a byte index (2 bits) SHALL select the bit and byte being sent; the bit counter wraps 7->0 at each byte end, which enters ACK.
REQ-025 SHALL apply clock stretching: while sclOut=1 and sclIn=0, the quarter counter holds and the tick does not advance.
REQ-026 In ACK after a transmitted byte, sdaIn=1 SHALL set ackErr and go to STOP_A, skipping all remaining bytes.
REQ-027 STOP_A SHALL drive sclOut=0, sdaOut=0 for 1 tick; STOP_B SHALL drive sclOut=1 for 1 tick; STOP_C SHALL drive sdaOut=1 for 1 tick, then enter DONE.
REQ-028 DONE SHALL pulse done=1 for exactly one cycle, then return to IDLE with cmdReady=1.
REQ-029 rdData SHALL update only at the end of the read byte and SHALL hold otherwise; a write or an aborted transaction leaves it unchanged.
REQ-030 cmdValid asserted while busy SHALL be ignored without side effects.
REQ-031 In IDLE, sclOut and sdaOut SHALL both be 1.

Reset
REQ-032 rst=1 at a clk edge SHALL force IDLE with sclOut=1, sdaOut=1, cmdReady=1, done=0, ackErr=0, rdData=8'h00, and all counters cleared.
REQ-033 rst mid-transaction SHALL abort it immediately with no STOP generated and no done pulse; the bus is released on the next cycle.

Verification
REQ-034 The bench SHALL cover: write, dev 7'h3C, reg 8'h05, data 8'hA5, slave ACKs all bytes -> SDA carries 78,05,A5; STOP; done pulses once; ackErr=0.
REQ-035 The bench SHALL cover: read, dev 7'h3C, slave returns 8'h5A -> address byte 79; rdData=8'h5A; master NAK at the 9th SCL; STOP; ackErr=0.
REQ-036 The bench SHALL cover: write to an absent device, SDA high at the first ACK -> ackErr=1; no reg/data bytes are sent; STOP; done pulses once.
REQ-037 The bench SHALL cover: slave holds sclIn=0 for 20 clk in bit 3 -> SCL high phase extends by 20 clk; data is still correct.
REQ-038 The bench SHALL cover: rst during the reg byte of a write -> next cycle sclOut=1, sdaOut=1, cmdReady=1; done never pulses.
REQ-039 The bench SHALL cover: QTR_DIV=4, one write -> SCL period is exactly 16 clk; START hold is 4 clk from SDA fall to SCL fall.
